mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage, owning the HI/LO registers.
//  It drives busy and receives start, the two signals the hazard unit uses to
//  stall MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO in D while an operation is in flight.
//  MFHI/MFLO read hi/lo directly. MTHI/MTLO write through hl_we.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low reset
//  start   in   1   1-cycle pulse from E: begin md_op using A/B
//  md_op   in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  A       in   32  rs operand (forwarded E value)
//  B       in   32  rt operand (forwarded E value)
//  hl_we   in   1   MTHI/MTLO write enable
//  hl_sel  in   1   0 = write LO, 1 = write HI (with hl_we)
//  busy    out  1   operation in progress
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, busy=0, hi=0, lo=0, counter=0, result temporaries=0.
//  States: IDLE, RUN.
//  IDLE, start=1 at edge k:
//   - capture the md_op result into hi_tmp/lo_tmp.
//   - load the counter with MULT_CYCLES or DIV_CYCLES.
//   - go to RUN; busy=1 after edge k.
//  RUN: decrement the counter each edge. At the edge where the counter reaches 0:
//   - commit hi<=hi_tmp, lo<=lo_tmp.
//   - busy<=0; return to IDLE.
//   - busy is high for exactly N cycles. New hi/lo are visible the cycle busy falls.
//   - A back-to-back start is accepted in that same IDLE cycle.
//  MULT: {hi,lo} = $signed(A)*$signed(B), full 64 bits. MULTU: unsigned 64-bit product.
//  DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
//   - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIVU: unsigned quotient in lo, remainder in hi.
//  Divide by zero (B=0, DIV or DIVU): timing as normal; on commit hi and lo keep their previous values.
//  hl_we=1 in IDLE with start=0: the selected register takes A at the next edge, no busy.
//  start=1 and hl_we=1 in the same cycle: start wins, hl_we ignored.
//  start or hl_we while in RUN: ignored. The hazard unit never issues these; the bench checks they have no effect.
//  Operands A/B may change after the start edge without affecting the result.
//  Reset asserted mid-RUN: abort immediately to IDLE. busy=0, hi=lo=0. The pending result is discarded.
//  hi and lo change only on a commit edge or an hl_we edge.
// TESTING
//  MULT A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
//  DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU A=7, B=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22.
//  hl_we=1, hl_sel=1, A=0x1234 in IDLE -> next cycle hi=0x1234, busy stays 0.
//   - Then start MULT, and assert start+hl_we mid-RUN -> both ignored, result unchanged.
//  Start DIV; drop reset at RUN cycle 4 -> busy=0, hi=lo=0 immediately.
//   - Release reset, start MULTU 2*3 -> lo=6 after 5 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed when the
// operation starts, held in temporaries, and committed after a fixed busy period.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hl_we,
  input  logic        hl_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        state_dbg
);

  // Handshake: start is honoured only while busy is low; hl_we likewise, and
  // start takes priority over hl_we when both are high in the same cycle.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        load, commit;
  logic [15:0] cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic        div_zero;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
    a_neg  = A[31];
    b_neg  = B[31];
    a_mag  = a_neg ? (32'd0 - A) : A;
    b_mag  = b_neg ? (32'd0 - B) : B;
    // Divisor forced non-zero so the quotient is always defined; a zero divisor
    // suppresses the commit instead.
    div_s_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
    div_u_den = (B == 32'd0) ? 32'd1 : B;
    q_mag  = a_mag / div_s_den;
    r_mag  = a_mag % div_s_den;
    q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
    q_u    = A / div_u_den;
    r_u    = A % div_u_den;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == 16'd1) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= 16'd0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      if (load) begin
        div_zero <= md_op[1] && (B == 32'd0);
        case (md_op)
          2'b00: begin hi_tmp <= prod_s[63:32]; lo_tmp <= prod_s[31:0]; cnt <= 16'(MULT_CYCLES); end
          2'b01: begin hi_tmp <= prod_u[63:32]; lo_tmp <= prod_u[31:0]; cnt <= 16'(MULT_CYCLES); end
          2'b10: begin hi_tmp <= r_s; lo_tmp <= q_s; cnt <= 16'(DIV_CYCLES); end
          default: begin hi_tmp <= r_u; lo_tmp <= q_u; cnt <= 16'(DIV_CYCLES); end
        endcase
      end else if (state == RUN) begin
        cnt <= cnt - 16'd1;
      end

      if (commit) begin
        if (!div_zero) begin
          hi <= hi_tmp;
          lo <= lo_tmp;
        end
      end else if (state == IDLE && hl_we && !start) begin
        if (hl_sel) hi <= A;
        else        lo <= A;
      end
    end
  end

  assign busy      = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operations compared against
// a plain-arithmetic model of HI/LO and of the busy duration.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A, B;
  logic        hl_we, hl_sel;
  logic        busy;
  logic [31:0] hi, lo;
  logic        state_dbg;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .hl_we(hl_we), .hl_sel(hl_sel), .busy(busy), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: HI/LO after an operation, from plain integer arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    case (op)
      2'b00: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        exp_hi = ps[63:32]; exp_lo = ps[31:0];
      end
      2'b01: begin
        pu = {32'b0, a} * {32'b0, b};
        exp_hi = pu[63:32]; exp_lo = pu[31:0];
      end
      2'b10: begin
        if (b != 32'd0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            exp_lo = 32'h80000000; exp_hi = 32'd0;
          end else begin
            sa = a; sb = b;
            exp_lo = sa / sb; exp_hi = sa % sb;
          end
        end
      end
      default: begin
        if (b != 32'd0) begin
          exp_lo = a / b; exp_hi = a % b;
        end
      end
    endcase
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where busy fell.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit also_we, input bit inject);
    int n_exp, cnt;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi; old_lo = exp_lo;
    n_exp  = op[1] ? DIV_N : MULT_N;
    start = 1'b1; md_op = op; A = a; B = b;
    hl_we = also_we; hl_sel = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; hl_we = 1'b0; A = $urandom; B = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 60) begin
      check("hi_hold", hi, old_hi);
      check("lo_hold", lo, old_lo);
      start = 1'b0; hl_we = 1'b0;
      if (inject && cnt == 2) begin
        start = 1'b1; hl_we = 1'b1; hl_sel = 1'($urandom_range(0, 1));
        md_op = 2'($urandom_range(0, 3));
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0; hl_we = 1'b0;
    model(op, a, b);
    check("busy_cycles", 32'(cnt), 32'(n_exp));
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
  endtask

  task automatic hl_write(input logic sel, input logic [31:0] val);
    start = 1'b0; hl_we = 1'b1; hl_sel = sel; A = val;
    @(negedge clk);
    hl_we = 1'b0;
    if (sel) exp_hi = val; else exp_lo = val;
    check("hl_busy", 32'(busy), 32'd0);
    check("hl_hi", hi, exp_hi);
    check("hl_lo", lo, exp_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    reset = 1'b0; start = 1'b0; md_op = 2'b00; A = '0; B = '0; hl_we = 1'b0; hl_sel = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_k_hi", hi, 32'hFFFFFFFF);
    check("mult_k_lo", lo, 32'hFFFFFFFA);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("multu_k_hi", hi, 32'hFFFFFFFE);
    check("multu_k_lo", lo, 32'h00000001);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_k_hi", hi, 32'hFFFFFFFF);
    check("div_k_lo", lo, 32'hFFFFFFFD);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("div_ovf_lo", lo, 32'h80000000);
    hl_write(1'b1, 32'h11);
    hl_write(1'b0, 32'h22);
    do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divz_k_hi", hi, 32'h11);
    check("divz_k_lo", lo, 32'h22);
    hl_write(1'b1, 32'h1234);
    check("mthi_k", hi, 32'h1234);
    do_op(2'b00, 32'd100, 32'hFFFFFFF6, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) hl_write(1'($urandom_range(0, 1)), $urandom);
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during RUN cycle 4 of a divide.
    start = 1'b1; md_op = 2'b10; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
    check("post_rst_lo", lo, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
